// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch controller.
//   state_t    : fetch FSM states
//   WORD_W     : instruction word width
//   LINE_WORDS : words per Instruction_Memory line
//   LINE_W     : line width
//   word_sel() : pick one 32-bit word out of a 128-bit line
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int WORD_W     = 32;
  localparam int LINE_WORDS = 4;
  localparam int LINE_W     = WORD_W * LINE_WORDS;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  // Word i of a line lives at line[32*i+31 : 32*i].
  function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                 input logic [1:0]        idx);
    logic [WORD_W-1:0] w;
    case (idx)
      2'd0:    w = line[0*WORD_W +: WORD_W];
      2'd1:    w = line[1*WORD_W +: WORD_W];
      2'd2:    w = line[2*WORD_W +: WORD_W];
      default: w = line[3*WORD_W +: WORD_W];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// -----------------------------------------------------------------------------
// fetch_controller_if
// Bundles the memory-side and decode-side signals of the fetch controller.
//   im_pc          : line address to Instruction_Memory
//   im_line        : line returned by Instruction_Memory
//   redirect_valid : one-cycle redirect strobe
//   redirect_pc    : redirect target
//   inst_valid     : inst / inst_pc valid toward decode
//   inst_ready     : decode accepts
//   inst           : instruction word
//   inst_pc        : address of inst
// master = fetch controller, slave = memory / decode / branch unit side.
// -----------------------------------------------------------------------------
interface fetch_controller_if;
  import fetch_pkg::*;

  logic [31:0]       im_pc;
  logic [LINE_W-1:0] im_line;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [WORD_W-1:0] inst;
  logic [31:0]       inst_pc;

  modport master (
    output im_pc,
    input  im_line,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    input  inst_ready,
    output inst,
    output inst_pc
  );

  modport slave (
    input  im_pc,
    output im_line,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    output inst_ready,
    input  inst,
    input  inst_pc
  );

endinterface

// File: rtl/fetch_line_buf.sv
// -----------------------------------------------------------------------------
// fetch_line_buf
// One-line instruction buffer: holds the last captured memory line, its tag
// (line address bits [31:4]) and a valid flag, and selects the word to issue.
//   clk, rst   : clock, synchronous active-high reset
//   capture    : load line_in / tag_in this cycle
//   line_in    : line from Instruction_Memory
//   tag_in     : pc[31:4] of the line being captured
//   word_idx   : pc[3:2], word to present on word
//   word       : selected instruction word
//   tag        : tag of the buffered line
//   line_valid : buffer holds a usable line
// -----------------------------------------------------------------------------
module fetch_line_buf
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic [LINE_W-1:0] line_in,
  input  logic [27:0]       tag_in,
  input  logic [1:0]        word_idx,
  output logic [WORD_W-1:0] word,
  output logic [27:0]       tag,
  output logic              line_valid
);

  logic [LINE_W-1:0] line_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q     <= '0;
      tag        <= '0;
      line_valid <= 1'b0;
    end else if (capture) begin
      line_q     <= line_in;
      tag        <= tag_in;
      line_valid <= 1'b1;
    end
  end

  assign word = word_sel(line_q, word_idx);

endmodule

// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
// Sequences Instruction_Memory line reads into a one-line buffer and issues one
// instruction per cycle to decode over valid/ready. Redirects that land in the
// buffered line are served without a memory access.
//   clk, rst : clock, synchronous active-high reset
//   en       : fetch enable; gates only the start of a new line request
//   bus      : fetch_controller_if.master (memory, redirect and decode signals)
// Parameters:
//   RESET_PC   : pc after reset (bits [1:0] ignored)
//   IM_LATENCY : cycles from stable im_pc to valid im_line, 1..7
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_REQ   | present line address; leave for S_WAIT once en=1
// S_WAIT  | hold im_pc, count down latency, capture line at count 0
// S_ISSUE | inst_valid=1, advance pc on each handshake to end of line
// -----------------------------------------------------------------------------
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IM_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  fetch_controller_if.master bus
);

  localparam logic [2:0] CNT_LOAD = 3'(IM_LATENCY - 1);

  state_t            state;
  logic [31:0]       pc;
  logic [2:0]        cnt;
  logic              inst_valid;

  logic [31:0]       target;
  logic              hit;
  logic              capture;
  logic [WORD_W-1:0] word;
  logic [27:0]       tag;
  logic              line_valid;

  assign target = bus.redirect_pc & 32'hFFFF_FFFC;
  assign hit    = line_valid && (target[31:4] == tag);

  // A redirect in the capture cycle aborts the access: the old line and tag
  // stay put so a later redirect back into them can still hit.
  assign capture = (state == S_WAIT) && (cnt == 3'd0) && !bus.redirect_valid;

  fetch_line_buf u_line_buf (
    .clk        (clk),
    .rst        (rst),
    .capture    (capture),
    .line_in    (bus.im_line),
    .tag_in     (pc[31:4]),
    .word_idx   (pc[3:2]),
    .word       (word),
    .tag        (tag),
    .line_valid (line_valid)
  );

  assign bus.im_pc      = {pc[31:4], 4'b0000};
  assign bus.inst_pc    = pc;
  assign bus.inst       = word;
  assign bus.inst_valid = inst_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC & 32'hFFFF_FFFC;
      cnt        <= '0;
      inst_valid <= 1'b0;
    end else if (bus.redirect_valid) begin
      // Redirect overrides everything, including a same-cycle handshake.
      pc  <= target;
      cnt <= '0;
      if (hit) begin
        state      <= S_ISSUE;
        inst_valid <= 1'b1;
      end else begin
        state      <= S_REQ;
        inst_valid <= 1'b0;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (en) begin
            state <= S_WAIT;
            cnt   <= CNT_LOAD;
          end
        end
        S_WAIT: begin
          if (cnt == 3'd0) begin
            state      <= S_ISSUE;
            inst_valid <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_ISSUE: begin
          if (bus.inst_ready) begin
            pc <= pc + 32'd4;
            if (pc[3:2] == 2'b11) begin
              state      <= S_REQ;
              inst_valid <= 1'b0;
            end
          end
        end
        default: begin
          state      <= S_REQ;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the 128-bit-line Instruction_Memory (pc in, 4-word line out, registered read) for the fetch stage.
- Drives the line address into the memory and captures the returned line into a one-line buffer.
- Issues one 32-bit instruction per cycle to decode over a valid/ready handshake.
- Handles redirects (branch/jump targets) with a same-line hit shortcut.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset. Bits [1:0] are ignored.
- IM_LATENCY, 1, cycles from a stable im_pc to a valid im_line. Legal range 1..7.

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- en  in  1  fetch enable; when low, no new line request leaves S_REQ
- im_pc  out  32  line address to Instruction_Memory: {pc[31:4],4'b0}
- im_line  in  128  line from Instruction_Memory; word i = im_line[32*i+31:32*i]
- redirect_valid  in  1  one-cycle redirect strobe
- redirect_pc  in  32  redirect target; bits [1:0] ignored
- inst_valid  out  1  inst/inst_pc valid
- inst_ready  in  1  decode accepts
- inst  out  32  instruction word
- inst_pc  out  32  address of inst

Behaviour:
- Reset values: pc=RESET_PC&~3, state=S_REQ, inst_valid=0, line_valid=0, wait counter=0.
- im_pc and inst_pc derive combinationally from pc. inst = buffer word pc[3:2].
- State S_REQ:
  - Drives im_pc.
  - If en=1, go to S_WAIT with counter=IM_LATENCY-1. Otherwise hold.
- State S_WAIT:
  - im_pc is held stable.
  - Counter decrements each cycle.
  - In the cycle the counter is 0: capture im_line into the buffer, set tag=pc[31:4], set line_valid=1, then go to S_ISSUE.
- State S_ISSUE:
  - inst_valid=1. inst/inst_pc are held stable while inst_ready=0.
  - On handshake, pc += 4.
  - If pc[3:2] was 3 (last word of the line), go to S_REQ with the next line. Otherwise stay.
  - Steady state: 4 instructions, then a bubble of 1+IM_LATENCY cycles.
- inst_valid is 0 in S_REQ and S_WAIT.
- First inst_valid after reset release: cycle 1+IM_LATENCY, counting the first cycle with rst=0 as cycle 0, en=1.
- Redirect has top priority over all state transitions.
  - The pc target is redirect_pc&~3.
  - If line_valid and target[31:4]==tag, go to S_ISSUE next cycle (hit, no memory access).
  - Otherwise go to S_REQ.
- Redirect in the same cycle as a handshake: the handshaked instruction counts as accepted, and the redirect still wins the pc update.
- Redirect while inst_valid=1 and inst_ready=0: the current instruction is dropped.
- Redirect in S_WAIT: the access is aborted with no capture. The buffer and tag keep their old contents.
- en=0 does not stall S_WAIT or S_ISSUE. Buffered words still issue.
- PC wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 0, and line 0 is requested.
- rst asserted in any state: reset values apply on the next edge. An in-flight access is discarded.

Decomposition:
- Package fetch_pkg holds:
  - state enum {S_REQ, S_WAIT, S_ISSUE}
  - WORD_W=32, LINE_WORDS=4, LINE_W=128
  - the word-select helper function
- Sub-module fetch_line_buf holds the 128-bit line register, the 28-bit tag, line_valid, the capture enable and the word mux by pc[3:2].
- The FSM, pc and counter stay in fetch_controller.

Test Plan:
- Reset: rst high 2 cycles, then low, IM_LATENCY=1, inst_ready=1, memory words = address.
  - inst_valid first in cycle 2 with inst_pc=0.
  - Then 4, 8, 12 on consecutive cycles.
  - Bubble of 2 cycles with im_pc=16.
  - inst_pc=16 appears in cycle 8.
- Backpressure: inst_ready=0 for 5 cycles at inst_pc=8 -> inst and inst_pc stay at 8/word 2. No pc advance. im_pc stays 0.
- Redirect miss: redirect to 32'h0000_0041 while issuing pc 4 -> next cycle S_REQ with im_pc=32'h40. Then inst_pc=32'h40, then 32'h44.
- Redirect hit: while in line 0x40, redirect to 32'h4C -> inst_valid=1 with inst_pc=32'h4C the next cycle. No S_REQ/S_WAIT visited.
- Abort and simultaneity:
  - Redirect to 32'h100 during S_WAIT for line 0x10 -> buffer is not loaded with line 0x10. im_pc=32'h100 next.
  - Redirect coinciding with a handshake -> handshaked pc is consumed once, and the next inst_pc is the target.
- Wrap and enable:
  - RESET_PC=32'hFFFF_FFF8 -> issues FFFF_FFF8 and FFFF_FFFC, then im_pc=0.
  - en=0 held in S_REQ -> inst_valid stays 0 until en=1.
